kgp_risc_mc_seq: RTL and testbench
==================================

Name: kgp_risc_mc_seq

Overview:
- Parametrised multi-cycle sequencer for the next-generation KGPRISC core. It replaces the single-cycle decoder and PC/branch logic.
- Holds the PC and a latched instruction register, and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Talks to instruction and data memory via a req/ack handshake, so memories may have wait states.
- Emits one-cycle control strobes to the existing register bank, ALU and memory-data muxes.

Parameters:
- XLEN, 32, datapath/PC width.
- PC_RESET, 0, PC value loaded on reset.
- PC_STEP, 4, PC increment per sequential instruction.
- TIMEOUT, 255, maximum wait cycles in FETCH or MEM before FAULT (8-bit counter).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- start  in  1  reset: synchronous, active-low. Low on a rising edge resets.
- imem_req  out  1  instruction fetch request; PC is the address.
- imem_ack  in  1  fetch complete; instr valid this cycle.
- instr  in  32  fetched instruction.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store (SW), 0 = load (LW); valid while dmem_req is high.
- dmem_ack  in  1  data access complete.
- zflag, carryflag, overflowflag, signflag  in  1 each  ALU flags, sampled in EXEC.
- rd1  in  XLEN  register operand, used as target by JR.
- label  in  XLEN  sign-extended branch target.
- PC  out  XLEN  program counter.
- ir  out  32  latched instruction.
- alu_en  out  1  ALU evaluate strobe.
- reg_we  out  1  register write strobe.
- ra_we  out  1  link register write strobe.
- link  out  XLEN  PC+PC_STEP, data for ra_we.
- mem_to_reg  out  1  register write data is selected from memory.
- stop  out  1  halted.
- fault  out  1  illegal opcode or timeout.
- instret  out  32  retired instruction count.
- cycles  out  32  cycle count.

Behaviour:
- Reset values:
  - state=FETCH, PC=PC_RESET, ir=0.
  - All strobes, req, stop and fault = 0.
  - Wait counter = 0; instret and cycles = 0.
  - A reset mid-operation aborts any pending request: req drops the cycle after the reset edge.
- Handshake:
  - req stays high until an edge where ack=1. ack is ignored when req is low.
  - A zero-wait memory acks in the first req cycle, so FETCH or MEM takes 1 cycle.
- Opcodes (instr[31:26]):
  - 00 ALU, 01 ALUI, 02 LW, 03 SW.
  - 10 B, 11 BL, 12 JR.
  - 13 BZ, 14 BNZ, 15 BCY, 16 BNCY, 17 BV, 18 BNV, 19 BS, 1A BNS.
  - 3F HALT. Any other value is illegal.
- FETCH: imem_req=1. On ack: ir<=instr, go to DECODE.
- DECODE (1 cycle):
  - illegal -> FAULT.
  - HALT -> HALT.
  - otherwise -> EXEC.
- EXEC (1 cycle, alu_en=1, flags latched):
  - ALU/ALUI -> WB.
  - LW/SW -> MEM.
  - B: PC<=label, -> FETCH.
  - BL: ra_we=1 and link=PC+PC_STEP this cycle; PC<=label, -> FETCH.
  - JR: PC<=rd1, -> FETCH.
  - Conditional branch: taken ? PC<=label : PC<=PC+PC_STEP; -> FETCH.
- MEM: dmem_req=1, dmem_we=(SW). On ack:
  - LW -> WB with mem_to_reg=1.
  - SW: PC<=PC+PC_STEP, -> FETCH.
- WB (1 cycle): reg_we=1, mem_to_reg held for LW. PC<=PC+PC_STEP, -> FETCH.
- Latency with zero-wait memories:
  - ALU/ALUI 4 cycles, LW 5, SW 4, branch/JR 3.
- HALT:
  - stop=1 until reset. PC is frozen at the HALT address.
- FAULT:
  - fault=1 and stop=1 until reset. PC is frozen at the faulting instruction.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle without ack.
  - When it reaches TIMEOUT without ack -> FAULT, with req dropped.
  - If ack arrives on the same edge the counter reaches TIMEOUT, the ack wins.
- PC arithmetic:
  - Modulo 2^XLEN; wrap from the maximum address to 0 is legal.
  - PC_RESET and label are not alignment-checked.
- instret increments on each transition out of WB, out of MEM for SW, and out of EXEC for branches. cycles increments every cycle not in reset. Both wrap at 2^32.

Optional Feature:
- KGP_SEQ_PERF_EN defined: instret and cycles counters are implemented as described.
- Undefined: both outputs are tied to 0 and no counter flops are generated. The port list is unchanged.

Decomposition:
- Package kgp_risc_pkg holds:
  - the opcode localparams (OP_ALU..OP_HALT);
  - the state enum typedef (FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT);
  - the branch-condition decode function.
- One sub-module, kgp_branch_cond: combinational opcode + flags -> taken.

Test Plan:
- Reset with start=0, then release; zero-wait imem; ALU instr at 0 -> FETCH, DECODE, EXEC, WB; reg_we one pulse in cycle 4; PC=4 after cycle 4; instret=1.
- LW at PC=8, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0; reg_we and mem_to_reg pulse in WB; PC=0xC.
- BZ with zflag=1, label=0x40 -> PC=0x40 after EXEC. Same with zflag=0 -> PC=PC+4. BL at 0x10 -> ra_we pulse with link=0x14.
- imem_ack never asserted, TIMEOUT=255 -> fault=1 and stop=1 after 256 FETCH cycles; imem_req low afterwards. Reset recovers to PC=PC_RESET.
- Opcode 0x2A -> FAULT in the cycle after DECODE. HALT (0x3F) -> stop=1, PC frozen, no further imem_req.
- start driven low while waiting in MEM -> dmem_req=0 after that edge, state=FETCH, PC=PC_RESET, counters=0.

Source files
------------

// File: rtl/kgp_risc_pkg.sv
// Shared opcode encodings, sequencer state type and branch-condition decode
// for the KGPRISC multi-cycle sequencer.
package kgp_risc_pkg;

   localparam logic [5:0] OP_ALU  = 6'h00;
   localparam logic [5:0] OP_ALUI = 6'h01;
   localparam logic [5:0] OP_LW   = 6'h02;
   localparam logic [5:0] OP_SW   = 6'h03;
   localparam logic [5:0] OP_B    = 6'h10;
   localparam logic [5:0] OP_BL   = 6'h11;
   localparam logic [5:0] OP_JR   = 6'h12;
   localparam logic [5:0] OP_BZ   = 6'h13;
   localparam logic [5:0] OP_BNZ  = 6'h14;
   localparam logic [5:0] OP_BCY  = 6'h15;
   localparam logic [5:0] OP_BNCY = 6'h16;
   localparam logic [5:0] OP_BV   = 6'h17;
   localparam logic [5:0] OP_BNV  = 6'h18;
   localparam logic [5:0] OP_BS   = 6'h19;
   localparam logic [5:0] OP_BNS  = 6'h1A;
   localparam logic [5:0] OP_HALT = 6'h3F;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT} state_t;

   function automatic logic is_cond_branch(input logic [5:0] op);
      return (op >= OP_BZ) && (op <= OP_BNS);
   endfunction

   function automatic logic is_legal(input logic [5:0] op);
      return (op <= OP_SW) || ((op >= OP_B) && (op <= OP_BNS)) || (op == OP_HALT);
   endfunction

   // Non-conditional opcodes report "not taken"; unconditional jumps are handled by the sequencer.
   function automatic logic branch_cond(input logic [5:0] op, input logic z, input logic c,
                                        input logic v, input logic s);
      logic t;
      t = 1'b0;
      case (op)
         OP_BZ:   t = z;
         OP_BNZ:  t = ~z;
         OP_BCY:  t = c;
         OP_BNCY: t = ~c;
         OP_BV:   t = v;
         OP_BNV:  t = ~v;
         OP_BS:   t = s;
         OP_BNS:  t = ~s;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/kgp_branch_cond.sv
// Combinational conditional-branch resolver: opcode plus ALU flags -> taken.
module kgp_branch_cond
   import kgp_risc_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic       zflag,
   input  logic       carryflag,
   input  logic       overflowflag,
   input  logic       signflag,
   output logic       taken
);

   always_comb begin
      taken = branch_cond(opcode, zflag, carryflag, overflowflag, signflag);
   end

endmodule

// File: rtl/kgp_risc_mc_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with req/ack memories.
// Define KGP_SEQ_PERF_EN to implement the instret/cycles counters (tied to 0 otherwise).
module kgp_risc_mc_seq
   import kgp_risc_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] PC_RESET = '0,
   parameter int              PC_STEP  = 4,
   parameter int              TIMEOUT  = 255
) (
   input  logic            clk,
   input  logic            start,
   output logic            imem_req,
   input  logic            imem_ack,
   input  logic [31:0]     instr,
   output logic            dmem_req,
   output logic            dmem_we,
   input  logic            dmem_ack,
   input  logic            zflag,
   input  logic            carryflag,
   input  logic            overflowflag,
   input  logic            signflag,
   input  logic [XLEN-1:0] rd1,
   input  logic [XLEN-1:0] label,
   output logic [XLEN-1:0] PC,
   output logic [31:0]     ir,
   output logic            alu_en,
   output logic            reg_we,
   output logic            ra_we,
   output logic [XLEN-1:0] link,
   output logic            mem_to_reg,
   output logic            stop,
   output logic            fault,
   output logic [31:0]     instret,
   output logic [31:0]     cycles
);

   state_t          state, next_state;
   logic            run;
   logic [7:0]      wait_cnt;
   logic [5:0]      op;
   logic            taken;
   logic            timed_out;
   logic            waiting;
   logic [XLEN-1:0] pc_inc;

   assign op        = ir[31:26];
   assign pc_inc    = PC + XLEN'(PC_STEP);
   assign link      = pc_inc;
   assign timed_out = (wait_cnt == 8'(TIMEOUT));
   assign waiting   = ((state == FETCH) && run && !imem_ack) || ((state == MEM) && !dmem_ack);

   kgp_branch_cond u_branch_cond (
      .opcode       (op),
      .zflag        (zflag),
      .carryflag    (carryflag),
      .overflowflag (overflowflag),
      .signflag     (signflag),
      .taken        (taken)
   );

   always_ff @(posedge clk) begin
      if (!start) state <= FETCH;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         FETCH: begin
            if (run) begin
               if (imem_ack)       next_state = DECODE;
               else if (timed_out) next_state = FAULT;
            end
         end
         DECODE: begin
            if (op == OP_HALT)     next_state = HALT;
            else if (!is_legal(op)) next_state = FAULT;
            else                   next_state = EXEC;
         end
         EXEC: begin
            if ((op == OP_ALU) || (op == OP_ALUI))    next_state = WB;
            else if ((op == OP_LW) || (op == OP_SW))  next_state = MEM;
            else                                      next_state = FETCH;
         end
         MEM: begin
            if (dmem_ack)       next_state = (op == OP_LW) ? WB : FETCH;
            else if (timed_out) next_state = FAULT;
         end
         WB:      next_state = FETCH;
         HALT:    next_state = HALT;
         FAULT:   next_state = FAULT;
         default: next_state = FETCH;
      endcase
   end

   always_comb begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      alu_en     = 1'b0;
      reg_we     = 1'b0;
      ra_we      = 1'b0;
      mem_to_reg = 1'b0;
      stop       = 1'b0;
      fault      = 1'b0;
      case (state)
         FETCH: imem_req = run;
         EXEC: begin
            alu_en = 1'b1;
            ra_we  = (op == OP_BL);
         end
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (op == OP_SW);
         end
         WB: begin
            reg_we     = 1'b1;
            mem_to_reg = (op == OP_LW);
         end
         HALT: stop = 1'b1;
         FAULT: begin
            stop  = 1'b1;
            fault = 1'b1;
         end
         default: ;
      endcase
   end

   // run holds requests low for the first cycle after a reset edge, so an
   // aborted handshake is never re-asserted while start is still low.
   always_ff @(posedge clk) begin
      if (!start) begin
         PC       <= PC_RESET;
         ir       <= '0;
         run      <= 1'b0;
         wait_cnt <= '0;
      end else begin
         run <= 1'b1;
         if ((state == FETCH) && run && imem_ack) ir <= instr;
         if (waiting && (next_state == state)) wait_cnt <= wait_cnt + 8'd1;
         else                                  wait_cnt <= '0;
         case (state)
            EXEC: begin
               if ((op == OP_B) || (op == OP_BL)) PC <= label;
               else if (op == OP_JR)              PC <= rd1;
               else if (is_cond_branch(op))       PC <= taken ? label : pc_inc;
            end
            MEM:     if (dmem_ack && (op == OP_SW)) PC <= pc_inc;
            WB:      PC <= pc_inc;
            default: ;
         endcase
      end
   end

`ifdef KGP_SEQ_PERF_EN
   logic retire;
   assign retire = (state == WB) ||
                   ((state == MEM) && dmem_ack && (op == OP_SW)) ||
                   ((state == EXEC) && (next_state == FETCH));

   always_ff @(posedge clk) begin
      if (!start) begin
         instret <= '0;
         cycles  <= '0;
      end else begin
         cycles <= cycles + 32'd1;
         if (retire) instret <= instret + 32'd1;
      end
   end
`else
   assign instret = '0;
   assign cycles  = '0;
`endif

endmodule

// File: tb/tb_kgp_risc_mc_seq.sv
// Directed self-checking bench for kgp_risc_mc_seq (works with or without KGP_SEQ_PERF_EN).
module tb_kgp_risc_mc_seq;
   import kgp_risc_pkg::*;

`ifdef KGP_SEQ_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        start, imem_req, imem_ack, imem_ready;
   logic [31:0] instr;
   logic        dmem_req, dmem_we, dmem_ack;
   logic        zflag, carryflag, overflowflag, signflag;
   logic [31:0] rd1, label, PC, ir, link, instret, cycles;
   logic        alu_en, reg_we, ra_we, mem_to_reg, stop, fault;

   int          tests = 0;
   int          fails = 0;
   int unsigned cyc   = 0;

   always #5 clk = ~clk;

   // Zero-wait instruction memory whenever imem_ready is set.
   assign imem_ack = imem_req & imem_ready;

   kgp_risc_mc_seq #(
      .XLEN     (32),
      .PC_RESET (32'h0),
      .PC_STEP  (4),
      .TIMEOUT  (255)
   ) dut (
      .clk          (clk),
      .start        (start),
      .imem_req     (imem_req),
      .imem_ack     (imem_ack),
      .instr        (instr),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_ack     (dmem_ack),
      .zflag        (zflag),
      .carryflag    (carryflag),
      .overflowflag (overflowflag),
      .signflag     (signflag),
      .rd1          (rd1),
      .label        (label),
      .PC           (PC),
      .ir           (ir),
      .alu_en       (alu_en),
      .reg_we       (reg_we),
      .ra_we        (ra_we),
      .link         (link),
      .mem_to_reg   (mem_to_reg),
      .stop         (stop),
      .fault        (fault),
      .instret      (instret),
      .cycles       (cycles)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_perf(input int unsigned ret);
      chk("instret", instret, PERF ? 64'(ret) : 64'd0);
      chk("cycles", cycles, PERF ? 64'(cyc) : 64'd0);
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (start) cyc++;
         else       cyc = 0;
         #1;
      end
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op);
      return {op, 26'h0};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      start = 1'b0; imem_ready = 1'b1; instr = mk(OP_ALU); dmem_ack = 1'b0;
      zflag = 1'b0; carryflag = 1'b0; overflowflag = 1'b0; signflag = 1'b0;
      rd1 = '0; label = '0;

      // Reset state
      tick(2);
      chk("rst_pc", PC, 0);
      chk("rst_ir", ir, 0);
      chk("rst_imem_req", imem_req, 0);
      chk("rst_stop", stop, 0);
      chk("rst_fault", fault, 0);
      chk_perf(0);

      // ALU at 0: FETCH, DECODE, EXEC, WB
      start = 1'b1;
      tick();
      chk("alu_fetch_req", imem_req, 1);
      chk("alu_fetch_regwe", reg_we, 0);
      tick();
      chk("alu_ir", ir, mk(OP_ALU));
      chk("alu_dec_req", imem_req, 0);
      tick();
      chk("alu_exec_en", alu_en, 1);
      tick();
      chk("alu_wb_regwe", reg_we, 1);
      chk("alu_wb_pc", PC, 0);
      tick();
      chk("alu_pc", PC, 32'h4);
      chk("alu_regwe_off", reg_we, 0);
      chk_perf(1);

      // ALUI at 4
      instr = mk(OP_ALUI);
      tick(4);
      chk("alui_pc", PC, 32'h8);

      // LW at 8 with 3 wait states
      instr = mk(OP_LW);
      tick(3);
      chk("lw_mem_req1", dmem_req, 1);
      chk("lw_mem_we", dmem_we, 0);
      tick();
      chk("lw_mem_req2", dmem_req, 1);
      tick();
      chk("lw_mem_req3", dmem_req, 1);
      tick();
      chk("lw_mem_req4", dmem_req, 1);
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      chk("lw_wb_regwe", reg_we, 1);
      chk("lw_wb_m2r", mem_to_reg, 1);
      chk("lw_wb_dreq", dmem_req, 0);
      tick();
      chk("lw_pc", PC, 32'hC);
      chk("lw_m2r_off", mem_to_reg, 0);
      chk_perf(3);

      // BZ taken, then not taken
      instr = mk(OP_BZ); zflag = 1'b1; label = 32'h40;
      tick(2);
      chk("bz_exec_pc", PC, 32'hC);
      tick();
      chk("bz_taken_pc", PC, 32'h40);
      zflag = 1'b0;
      tick(3);
      chk("bz_nt_pc", PC, 32'h44);

      // B to 0x10, then BL
      instr = mk(OP_B); label = 32'h10;
      tick(3);
      chk("b_pc", PC, 32'h10);
      instr = mk(OP_BL); label = 32'h80;
      tick(2);
      chk("bl_ra_we", ra_we, 1);
      chk("bl_link", link, 32'h14);
      tick();
      chk("bl_pc", PC, 32'h80);
      chk("bl_ra_off", ra_we, 0);

      // JR, then zero-wait SW
      instr = mk(OP_JR); rd1 = 32'h100;
      tick(3);
      chk("jr_pc", PC, 32'h100);
      instr = mk(OP_SW); dmem_ack = 1'b1;
      tick(3);
      chk("sw_mem_req", dmem_req, 1);
      chk("sw_mem_we", dmem_we, 1);
      tick();
      dmem_ack = 1'b0;
      chk("sw_pc", PC, 32'h104);
      chk_perf(9);

      // Illegal opcode 0x2A
      instr = 32'hA800_0000;
      tick();
      chk("ill_dec_fault", fault, 0);
      tick();
      chk("ill_fault", fault, 1);
      chk("ill_stop", stop, 1);
      chk("ill_pc", PC, 32'h104);
      tick(3);
      chk("ill_req", imem_req, 0);
      chk("ill_pc_frozen", PC, 32'h104);

      // Reset recovers; HALT at 0
      start = 1'b0;
      tick();
      chk("rst2_pc", PC, 0);
      chk("rst2_fault", fault, 0);
      chk("rst2_stop", stop, 0);
      chk("rst2_req", imem_req, 0);
      chk_perf(0);
      start = 1'b1; instr = mk(OP_HALT);
      tick();
      chk("halt_fetch_req", imem_req, 1);
      tick(2);
      chk("halt_stop", stop, 1);
      chk("halt_fault", fault, 0);
      tick(3);
      chk("halt_req", imem_req, 0);
      chk("halt_pc", PC, 0);

      // PC wrap through the top of the address space
      start = 1'b0; tick(); start = 1'b1;
      instr = mk(OP_JR); rd1 = 32'hFFFF_FFFC;
      tick(4);
      chk("wrap_jr_pc", PC, 32'hFFFF_FFFC);
      instr = mk(OP_ALU);
      tick(4);
      chk("wrap_pc", PC, 0);

      // Fetch timeout: 256 FETCH cycles then FAULT
      start = 1'b0; tick(); start = 1'b1; imem_ready = 1'b0;
      tick();
      tick(255);
      chk("to_pre_fault", fault, 0);
      chk("to_pre_req", imem_req, 1);
      tick();
      chk("to_fault", fault, 1);
      chk("to_stop", stop, 1);
      chk("to_req", imem_req, 0);
      start = 1'b0; tick(); start = 1'b1;
      tick();
      chk("to_rst_pc", PC, 0);
      chk("to_rst_fault", fault, 0);

      // Ack on the same edge the counter reaches TIMEOUT wins
      tick(255);
      imem_ready = 1'b1; instr = mk(OP_ALU);
      tick();
      chk("to_ack_fault", fault, 0);
      chk("to_ack_ir", ir, mk(OP_ALU));

      // Reset while waiting in MEM
      start = 1'b0; tick(); start = 1'b1;
      instr = mk(OP_LW); dmem_ack = 1'b0;
      tick(4);
      chk("mrst_mem_req", dmem_req, 1);
      start = 1'b0;
      tick();
      chk("mrst_dreq", dmem_req, 0);
      chk("mrst_ireq", imem_req, 0);
      chk("mrst_pc", PC, 0);
      chk_perf(0);
      start = 1'b1;
      tick();
      chk("mrst_fetch_req", imem_req, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
